rv_instr_encoder: RTL

- Pipelined RV32I instruction encoder, the inverse of the core's immediate/field decode.
- Packs format, opcode, register fields, functs and a 32-bit sign-extended immediate into a 32-bit instruction word.
- Used by the self-test sequencer and boot ROM loader to generate instruction-memory contents.
- Valid/ready on both sides; one-register pipeline plus skid buffer gives full throughput.

---
 rtl/rv_pkg.sv | 34 +++
 rtl/rv_instr_encoder_if.sv | 32 +++
 rtl/rv_instr_pack.sv | 62 ++++++
 rtl/rv_instr_encoder.sv | 107 ++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared definitions for the RV32I instruction encoder.
//   fmt_e        : request format code (R, I, S, B, U, J; 6-7 illegal)
//   OPC_*        : RV32I major opcodes used by the sequencer / ROM loader
//   NOP_WORD_DFLT: canonical NOP (addi x0,x0,0)
//   enc_res_t    : one encoded result (word + error flag)
package rv_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [31:0] NOP_WORD_DFLT = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } enc_res_t;

endpackage

// File: rtl/rv_instr_encoder_if.sv
// Request/response bus of the instruction encoder.
//   in_*  : request side (valid/ready + instruction fields, imm sign-extended)
//   out_* : response side (valid/ready + encoded word + error flag)
// master: request producer / response consumer. slave: the encoder.
interface rv_instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;

  modport master (
    output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_err
  );

  modport slave (
    input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_err
  );
endinterface

// File: rtl/rv_instr_pack.sv
// Combinational RV32I field packer.
//   fmt_i, opcode_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i : request
//   instr_o : packed 32-bit word (NOP_WORD for illegal fmt)
//   err_o   : illegal fmt, or immediate out of range when
//             RV_INSTR_ENC_RANGE_CHECK_EN is defined (word still encoded,
//             high bits truncated).
module rv_instr_pack
  import rv_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = NOP_WORD_DFLT
) (
  input  logic [2:0]  fmt_i,
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  output logic [31:0] instr_o,
  output logic        err_o
);

  logic illegal;
  logic rc_err;

  always_comb begin
    instr_o = NOP_WORD;
    illegal = 1'b0;
    case (fmt_i)
      FMT_R: instr_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
      FMT_I: instr_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
      FMT_S: instr_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
      FMT_B: instr_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                        imm_i[4:1], imm_i[11], opcode_i};
      FMT_U: instr_o = {imm_i[31:12], rd_i, opcode_i};
      FMT_J: instr_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12],
                        rd_i, opcode_i};
      default: illegal = 1'b1;
    endcase
  end

`ifdef RV_INSTR_ENC_RANGE_CHECK_EN
  // An immediate fits when every bit above the field's sign bit equals it,
  // i.e. the slice from the sign bit upward is all-ones or all-zeros.
  always_comb begin
    rc_err = 1'b0;
    case (fmt_i)
      FMT_I, FMT_S: rc_err = !((&imm_i[31:11]) || !(|imm_i[31:11]));
      FMT_B:        rc_err = !((&imm_i[31:12]) || !(|imm_i[31:12])) || imm_i[0];
      FMT_J:        rc_err = !((&imm_i[31:20]) || !(|imm_i[31:20])) || imm_i[0];
      FMT_U:        rc_err = |imm_i[11:0];
      default:      rc_err = 1'b0;
    endcase
  end
`else
  assign rc_err = 1'b0;
`endif

  assign err_o = illegal | rc_err;

endmodule

// File: rtl/rv_instr_encoder.sv
// Pipelined RV32I instruction encoder (inverse of the core's decode).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : rv_instr_encoder_if.slave (request in, encoded word out)
//   err_count  : saturating count of errored words taken by the consumer
// One output register plus a one-entry skid buffer: in_ready is a flop
// (!skid valid), so the upstream never sees a combinational path from
// out_ready, yet back-to-back transfers run at full rate.
// Optional macro RV_INSTR_ENC_RANGE_CHECK_EN enables immediate range
// checks and the error counter; without it err_count is tied to zero.
module rv_instr_encoder
  import rv_pkg::*;
#(
  parameter int          ERR_CNT_W = 16,
  parameter logic [31:0] NOP_WORD  = NOP_WORD_DFLT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rv_instr_encoder_if.slave    bus,
  output logic [ERR_CNT_W-1:0] err_count
);

  enc_res_t pack_res;
  enc_res_t out_q, out_d;
  enc_res_t skid_q, skid_d;
  logic     out_vld_q, out_vld_d;
  logic     skid_vld_q, skid_vld_d;
  logic     in_xfer, out_xfer;

  rv_instr_pack #(.NOP_WORD(NOP_WORD)) u_pack (
    .fmt_i    (bus.in_fmt),
    .opcode_i (bus.in_opcode),
    .rd_i     (bus.in_rd),
    .rs1_i    (bus.in_rs1),
    .rs2_i    (bus.in_rs2),
    .funct3_i (bus.in_funct3),
    .funct7_i (bus.in_funct7),
    .imm_i    (bus.in_imm),
    .instr_o  (pack_res.instr),
    .err_o    (pack_res.err)
  );

  assign bus.in_ready  = !skid_vld_q;
  assign bus.out_valid = out_vld_q;
  assign bus.out_instr = out_q.instr;
  assign bus.out_err   = out_q.err;

  assign in_xfer  = bus.in_valid && !skid_vld_q;
  assign out_xfer = out_vld_q && bus.out_ready;

  // Skid only fills while the output is stalled, so whenever the output
  // frees up with the skid full there can be no input transfer that cycle.
  always_comb begin
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (!out_vld_q || out_xfer) begin
      if (skid_vld_q) begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_vld_d = 1'b0;
      end else if (in_xfer) begin
        out_d     = pack_res;
        out_vld_d = 1'b1;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (in_xfer) begin
      skid_d     = pack_res;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
    end
  end

`ifdef RV_INSTR_ENC_RANGE_CHECK_EN
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (out_xfer && out_q.err && (err_cnt_q != '1))
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = '0;
`endif

endmodule
